// File: rtl/rf_pkg.sv
// Shared constants and types for the pipelined integer register file.
//   RF_AW        default address width for 32 registers
//   SP_INIT      reset value of the stack pointer register
//   SP_IDX       index of the stack pointer register (x2)
//   HALT_REG     register examined when an ecall reaches decode
//   HALT_VAL     value in HALT_REG that requests a halt
//   halt_state_e states of the sticky halt machine
//   busy_rule    "write outstanding and not yet visible" test shared by all lookups
package rf_pkg;

    localparam int          RF_XLEN      = 32;
    localparam int          RF_NREG      = 32;
    localparam int          RF_AW        = $clog2(RF_NREG);
    localparam int          RF_NUM_RD    = 2;
    localparam int          RF_MAX_INFL  = 3;
    localparam logic [31:0] SP_INIT      = 32'h0000_2ffc;
    localparam int          SP_IDX       = 2;
    localparam int          HALT_REG     = 17;
    localparam int          HALT_VAL     = 10;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } halt_state_e;

    // A register is busy when more than one write is in flight, or exactly
    // one is in flight and it is not the one being written back right now
    // (that one is already visible through the bypass path).
    function automatic logic busy_rule(input int unsigned cnt, input logic wb_hit);
        logic busy;
        if (cnt > 32'd1) begin
            busy = 1'b1;
        end else if (cnt == 32'd1) begin
            busy = !wb_hit;
        end else begin
            busy = 1'b0;
        end
        return busy;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// In-flight write scoreboard for the register file.
// Keeps one saturating-by-backpressure counter per register of writes that
// have issued but not yet written back, and answers busy queries.
//   clk, reset    clock, synchronous active-high reset (clears all counters)
//   issue_valid   instruction writing issue_rd leaves decode this cycle
//   issue_rd      destination of the issuing instruction
//   issue_ready   low when issue_rd already has MAX_INFL writes in flight
//   wb_valid      writeback strobe
//   wb_rd         writeback destination
//   qry_addr      NQ lookup addresses, query k at [k*AW +: AW]
//   qry_busy      per-query busy flag
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG     = RF_NREG,
    parameter int AW       = $clog2(NREG),
    parameter int MAX_INFL = RF_MAX_INFL,
    parameter int CW       = $clog2(MAX_INFL + 1),
    parameter int NQ       = RF_NUM_RD + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [NQ*AW-1:0] qry_addr,
    output logic [NQ-1:0]   qry_busy
);

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic          issue_acc;

    // Issue acceptance: x0 is always accepted and never tracked.
    always_comb begin
        issue_ready = 1'b1;
        if (issue_rd != '0) begin
            issue_ready = (cnt_q[issue_rd] < CW'(MAX_INFL));
        end else begin
            issue_ready = 1'b1;
        end
        issue_acc = issue_valid && issue_ready && (issue_rd != '0);
    end

    // Counter next-state: issue and writeback to the same register cancel out.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        for (int r = 1; r < NREG; r++) begin
            logic inc;
            logic dec;
            inc = issue_acc && (issue_rd == AW'(r));
            dec = wb_valid && (wb_rd == AW'(r));
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CW'(1);
            end else if (dec && !inc && (cnt_q[r] != '0)) begin
                // A writeback with nothing tracked is an untracked write; stay at 0.
                cnt_d[r] = cnt_q[r] - CW'(1);
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
        cnt_d[0] = '0;
    end

    // Counter registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Busy lookup per query port.
    always_comb begin
        qry_busy = '0;
        for (int k = 0; k < NQ; k++) begin
            logic [AW-1:0] a;
            a = qry_addr[k*AW +: AW];
            if (a != '0) begin
                qry_busy[k] = busy_rule(int'(unsigned'(cnt_q[a])),
                                        wb_valid && (wb_rd == a));
            end else begin
                qry_busy[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipelined_register_file.sv
// Integer register file for the pipelined RV32I core.
// NUM_RD combinational read ports with same-cycle writeback bypass, one
// synchronous write port, per-register in-flight scoreboard, and the sticky
// ecall-halt detector.
//   clk, reset    clock, synchronous active-high reset
//   rd_addr       read addresses, port k at [k*AW +: AW]
//   rd_data       bypassed read data, port k at [k*XLEN +: XLEN]
//   rd_busy       port k target still has a write in flight that is not visible
//   issue_valid   instruction writing issue_rd leaves decode
//   issue_rd      its destination
//   issue_ready   low when issue_rd is at MAX_INFL outstanding writes
//   wb_valid      writeback strobe
//   wb_rd, wb_din writeback destination and data
//   is_ecall      ecall in decode
//   halt_stall    ecall must wait for HALT_REG to settle
//   halted        sticky halt flag, cleared only by reset
//   dbg_addr      debug read address
//   dbg_data      raw array contents, no bypass
module pipelined_register_file
    import rf_pkg::*;
#(
    parameter int          XLEN     = RF_XLEN,
    parameter int          NREG     = RF_NREG,
    parameter int          NUM_RD   = RF_NUM_RD,
    parameter int          MAX_INFL = RF_MAX_INFL,
    parameter logic [31:0] SP_RST   = SP_INIT,
    parameter int          HREG     = HALT_REG,
    parameter int          HVAL     = HALT_VAL,
    parameter int          AW       = $clog2(NREG),
    parameter int          CW       = $clog2(MAX_INFL + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_rd,
    output logic                   issue_ready,
    input  logic                   wb_valid,
    input  logic [AW-1:0]          wb_rd,
    input  logic [XLEN-1:0]        wb_din,
    input  logic                   is_ecall,
    output logic                   halt_stall,
    output logic                   halted,
    input  logic [AW-1:0]          dbg_addr,
    output logic [XLEN-1:0]        dbg_data
);

    localparam logic [AW-1:0]   HALT_ADDR = AW'(HREG);
    localparam logic [XLEN-1:0] HALT_CODE = XLEN'(HVAL);

    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];
    halt_state_e     state_q;
    halt_state_e     state_d;
    logic            wb_en;
    logic [XLEN-1:0] hr_val;
    logic            hr_busy;
    logic [NUM_RD:0] qry_busy;

    assign wb_en = wb_valid && (wb_rd != '0);

    // Array next-state: one write per cycle, x0 is hard-wired to zero.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            rf_d[r] = rf_q[r];
        end
        if (wb_en) begin
            rf_d[wb_rd] = wb_din;
        end else begin
            rf_d[0] = '0;
        end
        rf_d[0] = '0;
    end

    // Array registers; reset loads zeros and the initial stack pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                rf_q[r] <= '0;
            end
            rf_q[SP_IDX] <= XLEN'(SP_RST);
        end else begin
            for (int r = 0; r < NREG; r++) begin
                rf_q[r] <= rf_d[r];
            end
        end
    end

    // Bypassed read ports: the value being written back wins over the array.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [AW-1:0] a;
            a = rd_addr[k*AW +: AW];
            if (a == '0) begin
                rd_data[k*XLEN +: XLEN] = '0;
            end else if (wb_valid && (wb_rd == a)) begin
                rd_data[k*XLEN +: XLEN] = wb_din;
            end else begin
                rd_data[k*XLEN +: XLEN] = rf_q[a];
            end
        end
    end

    // Halt register read uses the same bypass as the ports so that an ecall
    // can see the halt code in the cycle it is written back.
    always_comb begin
        if (wb_valid && (wb_rd == HALT_ADDR) && (HALT_ADDR != '0)) begin
            hr_val = wb_din;
        end else begin
            hr_val = rf_q[HALT_ADDR];
        end
    end

    assign dbg_data = rf_q[dbg_addr];

    // Query slot NUM_RD is the halt register; the rest are the read ports.
    rf_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .MAX_INFL (MAX_INFL),
        .CW       (CW),
        .NQ       (NUM_RD + 1)
    ) u_sb (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .qry_addr    ({HALT_ADDR, rd_addr}),
        .qry_busy    (qry_busy)
    );

    assign rd_busy = qry_busy[NUM_RD-1:0];
    assign hr_busy = qry_busy[NUM_RD];

    // Halt next-state and stall: HALTED is left only through reset.
    always_comb begin
        state_d    = state_q;
        halt_stall = is_ecall && hr_busy;
        case (state_q)
            ST_RUN: begin
                if (is_ecall && !hr_busy && (hr_val == HALT_CODE)) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Halt state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pipelined_register_file.sv
// Directed self-checking bench for pipelined_register_file (default parameters).
module tb_pipelined_register_file;

    localparam int AW   = 5;
    localparam int XLEN = 32;

    logic             clk;
    logic             reset;
    logic [2*AW-1:0]  rd_addr;
    logic [2*XLEN-1:0] rd_data;
    logic [1:0]       rd_busy;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic             issue_ready;
    logic             wb_valid;
    logic [AW-1:0]    wb_rd;
    logic [XLEN-1:0]  wb_din;
    logic             is_ecall;
    logic             halt_stall;
    logic             halted;
    logic [AW-1:0]    dbg_addr;
    logic [XLEN-1:0]  dbg_data;

    int checks_cnt;
    int errors_cnt;

    pipelined_register_file dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_din      (wb_din),
        .is_ecall    (is_ecall),
        .halt_stall  (halt_stall),
        .halted      (halted),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        wb_valid    = 1'b0;
        wb_rd       = 5'd0;
        wb_din      = 32'd0;
        is_ecall    = 1'b0;
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        reset      = 1'b1;
        rd_addr    = '0;
        dbg_addr   = 5'd2;
        idle();
        tick();
        reset = 1'b0;

        // Reset state
        set_rd(5'd2, 5'd5);
        #1;
        chk("rst_x2", rd_data[31:0], 32'h0000_2ffc);
        chk("rst_x5", rd_data[63:32], 32'h0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_busy", {30'd0, rd_busy}, 32'd0);
        chk("rst_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_dbg_x2", dbg_data, 32'h0000_2ffc);

        // Bypass on x5
        set_rd(5'd5, 5'd2);
        dbg_addr = 5'd5;
        wb_valid = 1'b1; wb_rd = 5'd5; wb_din = 32'hdead_beef;
        #1;
        chk("byp_x5", rd_data[31:0], 32'hdead_beef);
        chk("byp_dbg_old", dbg_data, 32'h0);
        chk("byp_busy", {30'd0, rd_busy}, 32'd0);
        tick();
        idle();
        #1;
        chk("arr_dbg_x5", dbg_data, 32'hdead_beef);
        chk("arr_rd_x5", rd_data[31:0], 32'hdead_beef);

        // Writes to x0 are dropped
        set_rd(5'd5, 5'd0);
        wb_valid = 1'b1; wb_rd = 5'd0; wb_din = 32'h0000_1234;
        #1;
        chk("x0_byp", rd_data[63:32], 32'h0);
        chk("x0_busy", {31'd0, rd_busy[1]}, 32'd0);
        tick();
        idle();
        dbg_addr = 5'd0;
        #1;
        chk("x0_arr", dbg_data, 32'h0);

        // Fill x7 to MAX_INFL
        set_rd(5'd7, 5'd0);
        issue_valid = 1'b1; issue_rd = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("x7_ready_%0d", i), {31'd0, issue_ready}, 32'd1);
            chk($sformatf("x7_busy_%0d", i), {31'd0, rd_busy[0]}, (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        chk("x7_full_ready", {31'd0, issue_ready}, 32'd0);
        tick();  // rejected issue, count stays 3
        chk("x7_reject_ready", {31'd0, issue_ready}, 32'd0);
        // Writeback alone: 3 -> 2
        issue_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_din = 32'h0000_0077;
        #1;
        chk("x7_busy_wb3", {31'd0, rd_busy[0]}, 32'd1);
        tick();
        // Issue and writeback together at 2: unchanged
        issue_valid = 1'b1; wb_din = 32'h0000_0078;
        #1;
        chk("x7_ready_at2", {31'd0, issue_ready}, 32'd1);
        tick();
        wb_valid = 1'b0;
        #1;
        chk("x7_same_ready", {31'd0, issue_ready}, 32'd1);
        tick();  // issue only: 2 -> 3
        issue_valid = 1'b0;
        #1;
        chk("x7_back_full", {31'd0, issue_ready}, 32'd0);
        // Drain 3 -> 0; the last writeback bypasses so busy drops with it
        wb_valid = 1'b1; wb_rd = 5'd7;
        tick();
        tick();
        #1;
        chk("x7_last_wb_busy", {31'd0, rd_busy[0]}, 32'd0);
        chk("x7_last_wb_data", rd_data[31:0], 32'h0000_0078);
        tick();
        idle();
        #1;
        chk("x7_drained_busy", {31'd0, rd_busy[0]}, 32'd0);

        // Halt via x17
        issue_valid = 1'b1; issue_rd = 5'd17;
        tick();
        idle();
        is_ecall = 1'b1;
        #1;
        chk("ecall_stall", {31'd0, halt_stall}, 32'd1);
        tick();
        chk("ecall_not_halted", {31'd0, halted}, 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd17; wb_din = 32'd10;
        #1;
        chk("ecall_wb_stall", {31'd0, halt_stall}, 32'd0);
        tick();
        idle();
        #1;
        chk("halted_set", {31'd0, halted}, 32'd1);
        chk("halt_stall_idle", {31'd0, halt_stall}, 32'd0);
        tick();
        chk("halted_sticky", {31'd0, halted}, 32'd1);

        // Leave x9 in flight, then reset with an issue to x9 in the same cycle
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        set_rd(5'd9, 5'd2);
        #1;
        chk("x9_busy_pre", {31'd0, rd_busy[0]}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_busy", {30'd0, rd_busy}, 32'd0);
        chk("rst2_x2", rd_data[63:32], 32'h0000_2ffc);

        // Ecall with x17 = 9: no halt
        wb_valid = 1'b1; wb_rd = 5'd17; wb_din = 32'd9;
        tick();
        idle();
        is_ecall = 1'b1;
        #1;
        chk("ecall9_stall", {31'd0, halt_stall}, 32'd0);
        tick();
        idle();
        #1;
        chk("ecall9_halted", {31'd0, halted}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
